// File: rtl/sequencer_if.sv
// Control-bus bundle between the sequencer and its datapath and display.
// io_req/io_ack: the sequencer raises io_req and holds it; the transfer completes on the rising edge where io_req and io_ack are both 1; io_ack at any other time is ignored.
interface sequencer_if #(
    parameter int OP_W = 3
);
    logic            start;
    logic [OP_W-1:0] op;
    logic            io_sel;
    logic            io_ack;

    logic            PC_bus;
    logic            IR_bus;
    logic            ACC_bus;
    logic            MDR_bus;
    logic            load_PC;
    logic            INC_PC;
    logic            load_IR;
    logic            load_MAR;
    logic            load_MDR;
    logic            load_ACC;
    logic            CS;
    logic            R_NW;
    logic [1:0]      alu_op;
    logic            io_req;
    logic            halted;
    logic [2:0]      state_dbg;

    modport master (
        output start, op, io_sel, io_ack,
        input  PC_bus, IR_bus, ACC_bus, MDR_bus, load_PC, INC_PC, load_IR,
               load_MAR, load_MDR, load_ACC, CS, R_NW, alu_op, io_req, halted,
               state_dbg
    );

    modport slave (
        input  start, op, io_sel, io_ack,
        output PC_bus, IR_bus, ACC_bus, MDR_bus, load_PC, INC_PC, load_IR,
               load_MAR, load_MDR, load_ACC, CS, R_NW, alu_op, io_req, halted,
               state_dbg
    );
endinterface

// File: rtl/sequencer.sv
// Microcoded-style control sequencer: fetch/execute FSM with registered Moore outputs.
// Outputs are decoded from the next state and next op register so they line up with the state register.
module sequencer #(
    parameter int OP_W = 3
) (
    input logic        clock,
    input logic        reset,
    sequencer_if.slave bus
);
    localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(0);
    localparam logic [OP_W-1:0] OP_STORE = OP_W'(1);
    localparam logic [OP_W-1:0] OP_XOR   = OP_W'(2);
    localparam logic [OP_W-1:0] OP_XNOR  = OP_W'(3);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH_A = 3'd1,
        S_FETCH_B = 3'd2,
        S_EXEC_A  = 3'd3,
        S_EXEC_B  = 3'd4,
        S_WAIT_IO = 3'd5,
        S_HALTED  = 3'd6
    } state_t;

    typedef struct packed {
        logic       pc_bus;
        logic       ir_bus;
        logic       acc_bus;
        logic       mdr_bus;
        logic       load_pc;
        logic       inc_pc;
        logic       load_ir;
        logic       load_mar;
        logic       load_mdr;
        logic       load_acc;
        logic       cs;
        logic       r_nw;
        logic [1:0] alu_op;
        logic       io_req;
        logic       halted;
    } ctrl_t;

    localparam ctrl_t CTRL_RST = '{r_nw: 1'b1, default: '0};

    state_t          r_state;
    logic [OP_W-1:0] r_op;
    ctrl_t           r_ctrl;

    state_t          w_next;
    logic [OP_W-1:0] w_op_next;
    ctrl_t           w_ctrl;

    always_comb begin
        w_next    = r_state;
        w_op_next = r_op;
        case (r_state)
            S_IDLE:    if (bus.start) w_next = S_FETCH_A;
            S_FETCH_A: w_next = S_FETCH_B;
            S_FETCH_B: w_next = S_EXEC_A;
            S_EXEC_A: begin
                w_op_next = bus.op;
                w_next    = S_EXEC_B;
            end
            S_EXEC_B: begin
                case (r_op)
                    OP_LOAD, OP_XOR, OP_XNOR: w_next = S_FETCH_A;
                    OP_STORE: w_next = bus.io_sel ? S_WAIT_IO : S_FETCH_A;
                    default:  w_next = S_HALTED;
                endcase
            end
            S_WAIT_IO: if (bus.io_ack) w_next = S_FETCH_A;
            S_HALTED:  w_next = S_HALTED;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_ctrl = CTRL_RST;
        case (w_next)
            S_FETCH_A: begin
                w_ctrl.pc_bus   = 1'b1;
                w_ctrl.load_mar = 1'b1;
            end
            S_FETCH_B: begin
                w_ctrl.cs      = 1'b1;
                w_ctrl.mdr_bus = 1'b1;
                w_ctrl.load_ir = 1'b1;
                w_ctrl.inc_pc  = 1'b1;
            end
            S_EXEC_A: begin
                w_ctrl.ir_bus   = 1'b1;
                w_ctrl.load_mar = 1'b1;
            end
            S_EXEC_B: begin
                case (w_op_next)
                    OP_LOAD, OP_XOR, OP_XNOR: begin
                        w_ctrl.cs       = 1'b1;
                        w_ctrl.mdr_bus  = 1'b1;
                        w_ctrl.load_acc = 1'b1;
                        w_ctrl.alu_op   = (w_op_next == OP_XOR)  ? 2'b01 :
                                          (w_op_next == OP_XNOR) ? 2'b10 : 2'b00;
                    end
                    OP_STORE: begin
                        w_ctrl.acc_bus  = 1'b1;
                        w_ctrl.load_mdr = 1'b1;
                        w_ctrl.cs       = 1'b1;
                        w_ctrl.r_nw     = 1'b0;
                    end
                    // A halting opcode already reports halted during its execute cycle.
                    default: w_ctrl.halted = 1'b1;
                endcase
            end
            S_WAIT_IO: w_ctrl.io_req = 1'b1;
            S_HALTED:  w_ctrl.halted = 1'b1;
            default:   w_ctrl = CTRL_RST;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_ctrl  <= CTRL_RST;
        end else begin
            r_state <= w_next;
            r_op    <= w_op_next;
            r_ctrl  <= w_ctrl;
        end
    end

    assign bus.PC_bus    = r_ctrl.pc_bus;
    assign bus.IR_bus    = r_ctrl.ir_bus;
    assign bus.ACC_bus   = r_ctrl.acc_bus;
    assign bus.MDR_bus   = r_ctrl.mdr_bus;
    assign bus.load_PC   = r_ctrl.load_pc;
    assign bus.INC_PC    = r_ctrl.inc_pc;
    assign bus.load_IR   = r_ctrl.load_ir;
    assign bus.load_MAR  = r_ctrl.load_mar;
    assign bus.load_MDR  = r_ctrl.load_mdr;
    assign bus.load_ACC  = r_ctrl.load_acc;
    assign bus.CS        = r_ctrl.cs;
    assign bus.R_NW      = r_ctrl.r_nw;
    assign bus.alu_op    = r_ctrl.alu_op;
    assign bus.io_req    = r_ctrl.io_req;
    assign bus.halted    = r_ctrl.halted;
    assign bus.state_dbg = r_state;
endmodule

// File: tb/tb_sequencer.sv
// Bench for the sequencer: instruction streams are expanded into expected per-cycle control words from the
// instruction-timing rules and compared against words sampled on the falling clock edge.
`timescale 1ns/1ps
module tb_sequencer;
  localparam int OP_W = 3;
  localparam logic [OP_W-1:0] OP_LOAD  = 3'd0;
  localparam logic [OP_W-1:0] OP_STORE = 3'd1;
  localparam logic [OP_W-1:0] OP_XOR   = 3'd2;
  localparam logic [OP_W-1:0] OP_XNOR  = 3'd3;
  localparam logic [OP_W-1:0] OP_HALT  = 3'd4;

  localparam int VW = 16;
  localparam logic [VW-1:0] V_PC   = 16'h8000;
  localparam logic [VW-1:0] V_IRB  = 16'h4000;
  localparam logic [VW-1:0] V_ACC  = 16'h2000;
  localparam logic [VW-1:0] V_MDRB = 16'h1000;
  localparam logic [VW-1:0] V_INC  = 16'h0400;
  localparam logic [VW-1:0] V_LIR  = 16'h0200;
  localparam logic [VW-1:0] V_LMAR = 16'h0100;
  localparam logic [VW-1:0] V_LMDR = 16'h0080;
  localparam logic [VW-1:0] V_LACC = 16'h0040;
  localparam logic [VW-1:0] V_CS   = 16'h0020;
  localparam logic [VW-1:0] V_RNW  = 16'h0010;
  localparam logic [VW-1:0] V_AXOR = 16'h0004;
  localparam logic [VW-1:0] V_AXNR = 16'h0008;
  localparam logic [VW-1:0] V_IORQ = 16'h0002;
  localparam logic [VW-1:0] V_HALT = 16'h0001;

  localparam logic [VW-1:0] E_FETCH_A = V_PC | V_LMAR | V_RNW;
  localparam logic [VW-1:0] E_FETCH_B = V_CS | V_RNW | V_MDRB | V_LIR | V_INC;
  localparam logic [VW-1:0] E_EXEC_A  = V_IRB | V_LMAR | V_RNW;
  localparam logic [VW-1:0] E_READ    = V_CS | V_RNW | V_MDRB | V_LACC;
  localparam logic [VW-1:0] E_STORE   = V_ACC | V_LMDR | V_CS;
  localparam logic [VW-1:0] E_HALTED  = V_HALT | V_RNW;
  localparam logic [VW-1:0] E_IDLE    = V_RNW;

  typedef struct {
    logic [OP_W-1:0] op;
    bit              sel;
    int              delay;
  } instr_t;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  bit   mon_en;

  logic [VW-1:0] exp_q[$];
  logic [VW-1:0] obs_q[$];
  instr_t        prog[$];

  sequencer_if #(.OP_W(OP_W)) bus ();

  sequencer #(.OP_W(OP_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [VW-1:0] obs_vec();
    return {bus.PC_bus, bus.IR_bus, bus.ACC_bus, bus.MDR_bus, bus.load_PC, bus.INC_PC,
            bus.load_IR, bus.load_MAR, bus.load_MDR, bus.load_ACC, bus.CS, bus.R_NW,
            bus.alu_op, bus.io_req, bus.halted};
  endfunction

  always @(negedge clock) if (mon_en) obs_q.push_back(obs_vec());

  always @(negedge clock)
    if (!reset) assert ($onehot0({bus.PC_bus, bus.IR_bus, bus.ACC_bus, bus.MDR_bus}));

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic randomize_inputs();
    bus.start  = 1'($urandom_range(0, 1));
    bus.op     = OP_W'($urandom_range(0, 7));
    bus.io_sel = 1'($urandom_range(0, 1));
    bus.io_ack = 1'($urandom_range(0, 1));
  endtask

  task automatic apply_reset();
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.op     = '0;
    bus.io_sel = 1'b0;
    bus.io_ack = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  function automatic bit is_halting(input logic [OP_W-1:0] op);
    return !(op == OP_LOAD || op == OP_STORE || op == OP_XOR || op == OP_XNOR);
  endfunction

  // Reference model: cycle-by-cycle control words of one instruction, straight from the timing rules.
  task automatic model_instr(input instr_t ins);
    exp_q.push_back(E_FETCH_A);
    exp_q.push_back(E_FETCH_B);
    exp_q.push_back(E_EXEC_A);
    if (ins.op == OP_LOAD)       exp_q.push_back(E_READ);
    else if (ins.op == OP_XOR)   exp_q.push_back(E_READ | V_AXOR);
    else if (ins.op == OP_XNOR)  exp_q.push_back(E_READ | V_AXNR);
    else if (ins.op == OP_STORE) begin
      exp_q.push_back(E_STORE);
      if (ins.sel) repeat (ins.delay + 1) exp_q.push_back(V_IORQ | V_RNW);
    end else exp_q.push_back(E_HALTED);
  endtask

  // Starts in FETCH_A; noise on unsampled inputs exercises the "ignored" rules.
  task automatic drive_instr(input instr_t ins);
    randomize_inputs(); tick();                       // FETCH_A
    randomize_inputs(); tick();                       // FETCH_B
    randomize_inputs(); bus.op = ins.op; tick();      // EXEC_A
    randomize_inputs(); bus.io_sel = ins.sel; tick(); // EXEC_B
    if (ins.op == OP_STORE && ins.sel) begin
      for (int k = 0; k <= ins.delay; k++) begin
        randomize_inputs();
        bus.io_ack = (k == ins.delay);
        tick();
      end
    end
  endtask

  task automatic run_program();
    bit stopped;
    stopped = 1'b0;
    apply_reset();
    exp_q.delete();
    obs_q.delete();
    randomize_inputs(); bus.start = 1'b1; tick();
    mon_en = 1'b1;
    foreach (prog[i]) begin
      model_instr(prog[i]);
      drive_instr(prog[i]);
      if (is_halting(prog[i].op)) begin
        stopped = 1'b1;
        break;
      end
    end
    if (stopped) begin
      repeat (4) begin
        exp_q.push_back(E_HALTED);
        randomize_inputs(); bus.start = 1'b1; tick();
      end
    end else begin
      exp_q.push_back(E_FETCH_A);
      randomize_inputs(); tick();
    end
    mon_en = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    randomize_inputs();
    #2;
    checks++;
    if (obs_vec() !== E_IDLE) begin
      errors++; $display("FAIL reset_async: got %h expected %h", obs_vec(), E_IDLE);
    end
    repeat (3) begin
      randomize_inputs(); bus.start = 1'b1; tick();
      checks++;
      if (obs_vec() !== E_IDLE) begin
        errors++; $display("FAIL reset_held: got %h expected %h", obs_vec(), E_IDLE);
      end
    end
    reset = 1'b0;
    repeat (3) begin
      randomize_inputs(); bus.start = 1'b0; tick();
      checks++;
      if (obs_vec() !== E_IDLE) begin
        errors++; $display("FAIL idle_hold: got %h expected %h", obs_vec(), E_IDLE);
      end
    end
    randomize_inputs(); bus.start = 1'b1; tick();
    checks++;
    if (obs_vec() !== E_FETCH_A) begin
      errors++; $display("FAIL idle_start: got %h expected %h", obs_vec(), E_FETCH_A);
    end
  endtask

  task automatic test_load();
    prog.delete();
    prog.push_back('{OP_LOAD, 1'b0, 0});
    run_program();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL load_len: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL load_cycle%0d: got %h expected %h", i + 1,
                           (i < obs_q.size()) ? obs_q[i] : 'x, exp_q[i]);
      end
    end
  endtask

  task automatic test_xor_xnor();
    prog.delete();
    prog.push_back('{OP_XOR, 1'b0, 0});
    prog.push_back('{OP_XNOR, 1'b1, 0});
    run_program();
    checks++;
    if (obs_q.size() != 9) begin
      errors++; $display("FAIL xor_xnor_len: got %0d expected 9", obs_q.size());
    end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL xor_xnor_cycle%0d: got %h expected %h", i + 1,
                           (i < obs_q.size()) ? obs_q[i] : 'x, exp_q[i]);
      end
    end
  endtask

  task automatic test_store_io();
    int ioreq_cycles;
    prog.delete();
    prog.push_back('{OP_STORE, 1'b1, 3});
    run_program();
    ioreq_cycles = 0;
    foreach (obs_q[i]) if (obs_q[i][1]) ioreq_cycles++;
    checks++;
    if (ioreq_cycles != 4) begin
      errors++; $display("FAIL store_io_req_cycles: got %0d expected 4", ioreq_cycles);
    end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL store_io_cycle%0d: got %h expected %h", i + 1,
                           (i < obs_q.size()) ? obs_q[i] : 'x, exp_q[i]);
      end
    end
  endtask

  task automatic test_store_noio();
    prog.delete();
    prog.push_back('{OP_STORE, 1'b0, 0});
    prog.push_back('{OP_LOAD, 1'b0, 0});
    run_program();
    foreach (exp_q[i]) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL store_noio_cycle%0d: got %h expected %h", i + 1,
                           (i < obs_q.size()) ? obs_q[i] : 'x, exp_q[i]);
      end
    end
  endtask

  task automatic test_halt();
    prog.delete();
    prog.push_back('{OP_HALT, 1'b0, 0});
    run_program();
    foreach (exp_q[i]) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL halt_cycle%0d: got %h expected %h", i + 1,
                           (i < obs_q.size()) ? obs_q[i] : 'x, exp_q[i]);
      end
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (obs_vec() !== E_IDLE) begin
      errors++; $display("FAIL halt_reset: got %h expected %h", obs_vec(), E_IDLE);
    end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_random_programs();
    logic [OP_W-1:0] ops[4] = '{OP_LOAD, OP_STORE, OP_XOR, OP_XNOR};
    for (int p = 0; p < 8; p++) begin
      prog.delete();
      for (int n = 0; n < int'($urandom_range(2, 6)); n++)
        prog.push_back('{ops[$urandom_range(0, 3)], 1'($urandom_range(0, 1)), int'($urandom_range(0, 4))});
      prog.push_back('{OP_W'($urandom_range(4, 7)), 1'b0, 0});
      run_program();
      checks++;
      if (obs_q.size() != exp_q.size()) begin
        errors++; $display("FAIL random%0d_len: got %0d expected %0d", p, obs_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) begin
        checks++;
        if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL random%0d_cycle%0d: got %h expected %h", p, i + 1,
                             (i < obs_q.size()) ? obs_q[i] : 'x, exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    apply_reset();
    randomize_inputs(); bus.start = 1'b1; tick();
    drive_instr('{OP_STORE, 1'b1, -1});   // io_ack never raised: stays in WAIT_IO
    randomize_inputs(); bus.io_ack = 1'b0; tick();
    checks++;
    if (bus.io_req !== 1'b1) begin
      errors++; $display("FAIL midwait_io_req: got %b expected 1", bus.io_req);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (obs_vec() !== E_IDLE) begin
      errors++; $display("FAIL midwait_async_reset: got %h expected %h", obs_vec(), E_IDLE);
    end
    tick();
    reset = 1'b0;
    repeat (3) begin
      randomize_inputs(); bus.start = 1'b0; tick();
      checks++;
      if (obs_vec() !== E_IDLE) begin
        errors++; $display("FAIL midwait_idle_hold: got %h expected %h", obs_vec(), E_IDLE);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    mon_en = 1'b0;
    test_reset();
    test_load();
    test_xor_xnor();
    test_store_io();
    test_store_noio();
    test_halt();
    test_random_programs();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
